uart_rx_sampler: RTL and testbench

- 8N1 UART receive front-end with 16x oversampling. Consumes the raw RX pin, delivers bytes to the receive FIFO write side over a valid/ready handshake.
- Sits directly upstream of the FIFO. Replaces the bare receiver with metastability hardening, mid-bit majority voting, false-start rejection, framing-error detection and overrun reporting.

---
 rtl/uart_rx_sampler.sv | 146 ++++++++++++++
 tb/tb_uart_rx_sampler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 mid-bit voting, false-start
// rejection, framing-error/break handling and a single-entry valid/ready output register.
module uart_rx_sampler #(
    parameter int BAUD_DIV = 5,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       sub_q, sub_d;
    logic [1:0]       vote_q, vote_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q;
    logic             valid_q, frame_err_q, overrun_q;

    logic rx_s, tick, vote;
    logic at_sample, at_end;
    logic shift_en, bit_inc, deliver, ferr_set;

    assign rx_s      = sync2_q;
    assign tick      = (div_q == DIV_W'(BAUD_DIV - 1));
    assign at_sample = tick && (sub_q == 4'd9);
    assign at_end    = tick && (sub_q == 4'd15);
    // Samples from sub 7 and 8 are held; the sub 9 sample is the live line.
    assign vote      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

    // State register (synchronizer flops reset to idle-high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: begin
                if (at_sample && vote) state_d = S_IDLE;
                else if (at_end)       state_d = S_DATA;
            end
            S_DATA:  if (at_end && (bit_idx_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (at_sample) state_d = vote ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        busy     = (state_q != S_IDLE);
        shift_en = (state_q == S_DATA) && at_sample;
        bit_inc  = (state_q == S_DATA) && at_end;
        deliver  = (state_q == S_STOP) && at_sample && vote;
        ferr_set = (state_q == S_STOP) && at_sample && !vote;
    end

    // Counters are held at zero in IDLE so every START begins at div=0, sub=0.
    always_comb begin
        div_d     = div_q;
        sub_d     = sub_q;
        vote_d    = vote_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (state_q == S_IDLE) begin
            div_d = '0;
            sub_d = 4'd0;
        end else if (tick) begin
            div_d = '0;
            sub_d = sub_q + 4'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (tick && (sub_q == 4'd7)) vote_d[0] = rx_s;
        if (tick && (sub_q == 4'd8)) vote_d[1] = rx_s;
        if (state_q == S_START) bit_idx_d = 3'd0;
        else if (bit_inc)       bit_idx_d = bit_idx_q + 3'd1;
        if (shift_en) shift_d = {vote, shift_q[7:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            sub_q       <= 4'd0;
            vote_q      <= 2'b00;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            sub_q       <= sub_d;
            vote_q      <= vote_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= ferr_set;
            overrun_q   <= 1'b0;
            // An accept in the delivery cycle frees the register for the new byte.
            if (deliver) begin
                if (!valid_q || data_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: 80-clk bits at BAUD_DIV=5, bytes checked
// against an expected queue when the consumer accepts them.
module tb_uart_rx_sampler;

    localparam int BIT_CLKS = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int ferr_cnt   = 0;
    int ovr_cnt    = 0;
    int rise_cyc   = 0;
    logic dv_prev  = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_sampler #(.BAUD_DIV(5), .DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse counters, latency capture and scoreboard, all sampled mid-cycle
    always @(negedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun)   ovr_cnt  <= ovr_cnt + 1;
        if (data_valid && !dv_prev) rise_cyc <= cyc;
        dv_prev <= data_valid;
        if (frame_err || overrun) check("ferr_ovr_exclusive", {31'd0, frame_err & overrun}, 32'd0);
        if (data_valid && data_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_byte", 32'd1, 32'd0);
            else check("sb_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
    end

    // Driver tasks; all are entered and left just after a rising edge
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic accept_one();
        data_ready = 1'b1;
        wait_clks(1);
        data_ready = 1'b0;
    endtask

    initial begin
        int t0;
        int lat;
        int ferr0;
        int ovr0;

        rst = 1'b1;
        rx = 1'b1;
        data_ready = 1'b0;
        wait_clks(3);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clks(5);

        // Single byte and start-to-valid latency
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        lat = rise_cyc - t0;
        check("a5_latency_in_range", {31'd0, (lat >= 772) && (lat <= 774)}, 32'd1);
        check("a5_valid", {31'd0, data_valid}, 32'd1);
        check("a5_data", {24'd0, data_out}, 32'hA5);
        check("a5_no_ferr", ferr_cnt, 32'd0);
        check("a5_no_ovr", ovr_cnt, 32'd0);
        accept_one();
        check("a5_valid_drop", {31'd0, data_valid}, 32'd0);

        // Short low glitch is rejected as a false start
        rx = 1'b0;
        wait_clks(30);
        rx = 1'b1;
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        wait_clks(60);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", {31'd0, data_valid}, 32'd0);
        check("glitch_no_ferr", ferr_cnt, 32'd0);

        // Framing error followed by a held-low line, then recovery
        ferr0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        wait_clks(400);
        check("brk_one_ferr", ferr_cnt - ferr0, 32'd1);
        check("brk_no_valid", {31'd0, data_valid}, 32'd0);
        check("brk_busy_held", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_clks(5);
        check("brk_busy_released", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("r81_valid", {31'd0, data_valid}, 32'd1);
        check("r81_data", {24'd0, data_out}, 32'h81);
        accept_one();
        check("r81_valid_drop", {31'd0, data_valid}, 32'd0);

        // Overrun: second byte arrives while the first is still held
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_one_pulse", ovr_cnt - ovr0, 32'd1);
        check("ovr_data_held", {24'd0, data_out}, 32'h11);
        check("ovr_valid_held", {31'd0, data_valid}, 32'd1);
        accept_one();
        check("ovr_valid_drop", {31'd0, data_valid}, 32'd0);

        // Accept lands in the exact cycle the second byte is delivered
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                wait_clks(10 * BIT_CLKS + 772);
                accept_one();
            end
        join
        check("sim_valid_kept", {31'd0, data_valid}, 32'd1);
        check("sim_data_new", {24'd0, data_out}, 32'h22);
        check("sim_no_ovr", ovr_cnt - ovr0, 32'd0);
        accept_one();
        check("sim_valid_drop", {31'd0, data_valid}, 32'd0);

        // Reset mid-frame discards both the held byte and the partial frame
        send_frame(8'h77, 1'b1);
        check("pre_rst_held", {31'd0, data_valid}, 32'd1);
        ferr0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_clks(5 * BIT_CLKS + 40);
                rst = 1'b1;
                wait_clks(1);
                rst = 1'b0;
                check("mid_rst_data_out", {24'd0, data_out}, 32'h00);
                check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
                check("mid_rst_busy", {31'd0, busy}, 32'd0);
                check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
                check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
            end
        join
        check("ff_not_delivered", {31'd0, data_valid}, 32'd0);
        check("ff_no_ferr", ferr_cnt - ferr0, 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        check("r5a_valid", {31'd0, data_valid}, 32'd1);
        check("r5a_data", {24'd0, data_out}, 32'h5A);
        accept_one();
        check("r5a_valid_drop", {31'd0, data_valid}, 32'd0);

        wait_clks(2);
        check("sb_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
